alu_sequencer: RTL and testbench

//  Multi-cycle control FSM for the accumulator datapath. Fetches 9-bit instructions,

---
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle control FSM for the accumulator datapath. It fetches 9-bit
//   instructions, decodes them, drives the combinational ALU from the IR and
//   sequences the regfile, accumulator and data-memory strobes. It owns the
//   PC, the instruction register and the carry/overflow flag.
//
// Ports
//   Clk, Reset            clock (rising edge), async active-high reset
//   Start                 one-cycle pulse, begins execution at PC=0
//   Done / Busy           HALTED / FETCH..WB status
//   imem_addr, imem_data  instruction ROM (data valid one cycle after addr)
//   alu_op, alu_imm, alu_ovf_in             ALU controls taken from IR / flag
//   alu_ovf_out, alu_branch, alu_out        ALU results
//   reg_sel, acc_we, reg_we, dmem_re, dmem_we, wb_mem   datapath strobes
module alu_sequencer #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned RSEL_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Done,
  output logic              Busy,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [8:0]        imem_data,
  output logic [3:0]        alu_op,
  output logic [8:0]        alu_imm,
  output logic              alu_ovf_in,
  input  logic              alu_ovf_out,
  input  logic              alu_branch,
  input  logic [7:0]        alu_out,
  output logic [RSEL_W-1:0] reg_sel,
  output logic              acc_we,
  output logic              reg_we,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic              wb_mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  localparam logic [3:0] OP_SET  = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_BT   = 4'b0111;
  localparam logic [3:0] OP_BF   = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            ovf_q, ovf_d;

  // Opcode decode; IR[8]=0 is an immediate regardless of IR[7:4].
  logic is_set, is_lw, is_sw, is_add, is_branch, is_halt;

  always_comb begin
    is_set    = ir_q[8] && (ir_q[7:4] == OP_SET);
    is_lw     = ir_q[8] && (ir_q[7:4] == OP_LW);
    is_sw     = ir_q[8] && (ir_q[7:4] == OP_SW);
    is_add    = ir_q[8] && (ir_q[7:4] == OP_ADD);
    is_branch = ir_q[8] && ((ir_q[7:4] == OP_BT) || (ir_q[7:4] == OP_BF));
    is_halt   = ir_q[8] && (ir_q[7:4] == OP_HALT);
  end

  // State register plus architectural registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 9'h100;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (Start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt)                        state_d = S_HALTED;
        else if (is_lw || is_sw)            state_d = S_MEM;
        else if (is_set || is_branch)       state_d = S_FETCH;
        else                                state_d = S_WB;
      end
      S_MEM:    state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALTED: if (Start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // PC / IR / flag updates.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    ovf_d = ovf_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d  = '0;
          ovf_d = 1'b0;
        end
      end
      S_DECODE: ir_d = imem_data;
      S_EXEC: begin
        if (is_branch && alu_branch) pc_d = PC_W'(alu_out);
        else if (!is_halt)           pc_d = pc_q + PC_W'(1);
        if (is_add) ovf_d = alu_ovf_out;
      end
      default: ;
    endcase
  end

  // Moore outputs. Async reset clears state_q, so every strobe drops as soon
  // as Reset rises, without waiting for a clock edge.
  always_comb begin
    Done    = 1'b0;
    Busy    = 1'b0;
    acc_we  = 1'b0;
    reg_we  = 1'b0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    wb_mem  = 1'b0;
    unique case (state_q)
      S_FETCH, S_DECODE: Busy = 1'b1;
      S_EXEC: begin
        Busy   = 1'b1;
        reg_we = is_set;
      end
      S_MEM: begin
        Busy    = 1'b1;
        dmem_re = is_lw;
        dmem_we = is_sw;
      end
      S_WB: begin
        Busy   = 1'b1;
        acc_we = 1'b1;
        wb_mem = is_lw;
      end
      S_HALTED: Done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    imem_addr  = pc_q;
    alu_op     = ir_q[7:4];
    alu_imm    = ir_q;
    alu_ovf_in = ovf_q;
    reg_sel    = ir_q[RSEL_W-1:0];
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. A small reference model expands each
// instruction into the per-cycle output vectors it should produce; those are
// queued up front and compared cycle by cycle on the falling clock edge.
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Done, Busy;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [3:0] alu_op;
  logic [8:0] alu_imm;
  logic       alu_ovf_in;
  logic       alu_ovf_out;
  logic       alu_branch;
  logic [7:0] alu_out;
  logic [3:0] reg_sel;
  logic       acc_we, reg_we, dmem_re, dmem_we, wb_mem;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.PC_W(10), .RSEL_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .Busy(Busy),
    .imem_addr(imem_addr), .imem_data(imem_data), .alu_op(alu_op),
    .alu_imm(alu_imm), .alu_ovf_in(alu_ovf_in), .alu_ovf_out(alu_ovf_out),
    .alu_branch(alu_branch), .alu_out(alu_out), .reg_sel(reg_sel),
    .acc_we(acc_we), .reg_we(reg_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .wb_mem(wb_mem)
  );

  always #5 Clk = ~Clk;

  // Instruction ROM with one cycle of read latency.
  logic [8:0] rom [0:1023];
  always @(posedge Clk) imem_data <= rom[imem_addr];

  // Vector: busy,done,acc_we,reg_we,dmem_re,dmem_we,wb_mem | addr | imm | ovf
  typedef struct {
    string       tag;
    logic [26:0] v;
  } exp_t;

  exp_t sb[$];

  logic [9:0] m_pc;
  logic [8:0] m_ir;
  logic       m_ovf;

  function automatic logic [26:0] mk(input logic busy, input logic done,
                                     input logic acc, input logic rw,
                                     input logic re, input logic we,
                                     input logic wbm, input logic [9:0] a,
                                     input logic [8:0] imm, input logic ov);
    return {busy, done, acc, rw, re, we, wbm, a, imm, ov};
  endfunction

  function automatic logic [26:0] observed();
    return {Busy, Done, acc_we, reg_we, dmem_re, dmem_we, wb_mem,
            imem_addr, alu_imm, alu_ovf_in};
  endfunction

  task automatic push(input string tag, input logic [26:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Expand the instruction at m_pc into its expected cycles.
  task automatic push_instr(input string tag);
    logic [8:0] ins;
    logic [3:0] op;
    logic       r;
    logic [9:0] npc;
    ins = rom[m_pc];
    r   = ins[8];
    op  = ins[7:4];
    push({tag, "/fetch"},  mk(1, 0, 0, 0, 0, 0, 0, m_pc, m_ir, m_ovf));
    push({tag, "/decode"}, mk(1, 0, 0, 0, 0, 0, 0, m_pc, m_ir, m_ovf));
    m_ir = ins;
    push({tag, "/exec"},
         mk(1, 0, 0, r && op == 4'h1, 0, 0, 0, m_pc, m_ir, m_ovf));
    if (r && (op == 4'h7 || op == 4'h8) && alu_branch) npc = {2'b00, alu_out};
    else if (r && op == 4'hF)                          npc = m_pc;
    else                                               npc = m_pc + 10'd1;
    if (r && op == 4'h4) m_ovf = alu_ovf_out;
    m_pc = npc;
    if (r && op == 4'hF)
      push({tag, "/halted"}, mk(0, 1, 0, 0, 0, 0, 0, m_pc, m_ir, m_ovf));
    else if (r && op == 4'h2) begin
      push({tag, "/mem"}, mk(1, 0, 0, 0, 1, 0, 0, m_pc, m_ir, m_ovf));
      push({tag, "/wb"},  mk(1, 0, 1, 0, 0, 0, 1, m_pc, m_ir, m_ovf));
    end else if (r && op == 4'h3)
      push({tag, "/mem"}, mk(1, 0, 0, 0, 0, 1, 0, m_pc, m_ir, m_ovf));
    else if (r && (op == 4'h1 || op == 4'h7 || op == 4'h8))
      ;
    else
      push({tag, "/wb"}, mk(1, 0, 1, 0, 0, 0, 0, m_pc, m_ir, m_ovf));
  endtask

  task automatic push_hold(input int n);
    for (int i = 0; i < n; i++)
      push("halted_hold", mk(0, 1, 0, 0, 0, 0, 0, m_pc, m_ir, m_ovf));
  endtask

  task automatic start_pulse();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Pops one expected vector per cycle. start_at >= 0 raises Start for one
  // cycle after that many vectors, to show it is ignored mid-instruction.
  task automatic run_sb(input int start_at);
    exp_t        e;
    logic [26:0] o;
    int          n;
    n = 0;
    while (sb.size() > 0) begin
      @(negedge Clk);
      e = sb.pop_front();
      o = observed();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: got flags=%b addr=%h imm=%h ovf=%b, want flags=%b addr=%h imm=%h ovf=%b",
                 e.tag, o[26:20], o[19:10], o[9:1], o[0],
                 e.v[26:20], e.v[19:10], e.v[9:1], e.v[0]);
      end
      Start = (n == start_at);
      n++;
    end
    Start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    logic [26:0] o;
    o = observed();
    checks++;
    if (o !== mk(0, 0, 0, 0, 0, 0, 0, 10'h000, 9'h100, 0)) begin
      errors++;
      $display("FAIL %s: got flags=%b addr=%h imm=%h ovf=%b, want flags=0000000 addr=000 imm=100 ovf=0",
               tag, o[26:20], o[19:10], o[9:1], o[0]);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_ir  = 9'h100;
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    Reset       = 1'b1;
    Start       = 1'b0;
    alu_ovf_out = 1'b0;
    alu_branch  = 1'b0;
    alu_out     = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h1F0;
    repeat (2) @(posedge Clk);
    #1;
    check_idle("reset_state");
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check_idle("start_during_reset");
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check_idle("idle_without_start");
    model_reset();
  endtask

  task automatic test_program();
    alu_ovf_out = 1'b1;
    alu_branch  = 1'b1;
    alu_out     = 8'h40;
    rom[10'h000] = 9'h005;
    rom[10'h001] = 9'h142;
    rom[10'h002] = 9'h170;
    rom[10'h040] = 9'h123;
    rom[10'h041] = 9'h133;
    rom[10'h042] = 9'h113;
    rom[10'h043] = 9'h1A5;
    rom[10'h044] = 9'h04F;
    rom[10'h045] = 9'h1F0;
    m_pc  = '0;
    m_ovf = 1'b0;
    push_instr("imm005");
    push_instr("add_r2");
    push_instr("bt_taken");
    push_instr("lw");
    push_instr("sw");
    push_instr("set");
    push_instr("alu_op_a");
    push_instr("imm04f");
    push_instr("halt");
    push_hold(3);
    start_pulse();
    run_sb(5);
  endtask

  task automatic test_restart_not_taken();
    alu_ovf_out = 1'b1;
    alu_branch  = 1'b0;
    alu_out     = 8'h40;
    rom[10'h000] = 9'h04A;
    rom[10'h001] = 9'h170;
    rom[10'h002] = 9'h180;
    rom[10'h003] = 9'h157;
    rom[10'h004] = 9'h1F0;
    m_pc  = '0;
    m_ovf = 1'b0;
    push_instr("imm_like_add");
    push_instr("bt_not_taken");
    push_instr("bf_not_taken");
    push_instr("sub");
    push_instr("halt2");
    push_hold(2);
    start_pulse();
    run_sb(-1);
  endtask

  task automatic test_reset_mid();
    // sw: reset lands before MEM, so dmem_we must never rise.
    rom[10'h000] = 9'h133;
    m_pc  = '0;
    m_ovf = 1'b0;
    push_instr("sw_abort");
    void'(sb.pop_back());
    start_pulse();
    run_sb(-1);
    Reset = 1'b1;
    #1;
    check_idle("sw_abort_async");
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      checks++;
      if (dmem_we !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL sw_abort_hold: got dmem_we=%b busy=%b, want 0 0", dmem_we, Busy);
      end
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    // lw: reset while dmem_re is high drops it without a clock edge.
    rom[10'h000] = 9'h123;
    push_instr("lw_abort");
    void'(sb.pop_back());
    start_pulse();
    run_sb(-1);
    Reset = 1'b1;
    #1;
    check_idle("lw_abort_async");
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_idle("lw_abort_idle");
    model_reset();
  endtask

  // Immediates only; opcode-like bit patterns with IR[8]=0 must not branch.
  task automatic test_pc_wrap();
    logic [7:0] lo;
    alu_branch  = 1'b1;
    alu_out     = 8'h00;
    alu_ovf_out = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      lo     = i[7:0];
      rom[i] = {1'b0, lo};
    end
    m_pc  = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < 1025; i++) push_instr("wrap");
    start_pulse();
    run_sb(-1);
    Reset = 1'b1;
    #1;
    check_idle("final_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_program();
    test_restart_not_taken();
    test_reset_mid();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
